// File: rtl/onehot_sequencer.sv
// ---------------------------------------------------------------------------
// onehot_sequencer
//   Registered binary-to-one-hot decoder with a request/done handshake.
//   It drives one-hot strobes such as register-file or round-key write
//   enables.
//     single mode (mode_i=0) : strobe the line selected by sel_i
//     scan mode   (mode_i=1) : sweep lines sel_i..last_i, wrapping past the
//                              top index back to 0
//   Each active line is held for DWELL cycles.
//
// Handshake: go_i is a request that is accepted on a rising edge where the
//   block is IDLE and en_i=1. busy_o stays high from the accepting edge until
//   the completion edge. On the completion edge done_o pulses for one cycle,
//   and the block is IDLE again. A go_i in the done_o cycle is accepted.
//   A go_i while busy is dropped, so the requester waits for done_o.
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    synchronous reset, active-high; aborts any request with no done
//   en_i     global enable; low pauses the block (out_o=0, state frozen)
//   mode_i   0 = single, 1 = scan; captured when go_i is accepted
//   sel_i    single index or scan start; captured when go_i is accepted
//   last_i   scan end index (inclusive); captured when go_i is accepted
//   go_i     request
//   busy_o   request in progress
//   done_o   one-cycle completion pulse
//   out_o    one-hot strobe; either all-zero or exactly one bit set
//   state_o  debug view of the FSM state (0 = IDLE, 1 = ACTIVE)
// All outputs come from flops.
// ---------------------------------------------------------------------------
module onehot_sequencer #(
  parameter int SEL_W = 4,
  parameter int DWELL = 1,   // legal range 1..255
  parameter bit HOLD  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [SEL_W-1:0]      last_i,
  input  logic                  go_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2**SEL_W-1:0]   out_o,
  output logic                  state_o
);

  localparam int N = 2**SEL_W;
  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q,  mode_d;
  logic [SEL_W-1:0]   last_q,  last_d;
  logic [SEL_W-1:0]   idx_q,   idx_d;
  logic [7:0]         cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [N-1:0]       out_q,   out_d;
  logic [SEL_W-1:0]   idx_inc;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Natural SEL_W-bit overflow gives the wrap from the top line to line 0.
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;

    if (!en_i) begin
      // Pause: strobe off, everything else frozen (busy_o included).
      out_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Without a new request out_q keeps its value: zero when HOLD=0,
          // the held last line when HOLD=1 (unless a pause cleared it).
          if (go_i) begin
            state_d = ACTIVE;
            mode_d  = mode_i;
            last_d  = last_i;
            idx_d   = sel_i;
            cnt_d   = DWELL_M1;
            busy_d  = 1'b1;
            out_d   = onehot(sel_i);
          end
        end
        ACTIVE: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 1'b1;
            out_d = onehot(idx_q);
          end else if (!mode_q || (idx_q == last_q)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            out_d   = HOLD ? onehot(idx_q) : '0;
          end else begin
            idx_d = idx_inc;
            cnt_d = DWELL_M1;
            out_d = onehot(idx_inc);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      last_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign out_o   = out_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_onehot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_onehot_sequencer
//   Three sequencers share one stimulus stream:
//     dut 0 : DWELL=1, HOLD=0
//     dut 1 : DWELL=2, HOLD=0
//     dut 2 : DWELL=3, HOLD=1
//   A reference model runs at each rising edge. It holds the pending strobe
//   cycles of a request as a queue of line numbers, where each line appears
//   DWELL times. After each edge it pushes the expected {busy, done, out}
//   into exp_q. A monitor on the falling edge pops the expected value and
//   compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_onehot_sequencer;

  localparam int ND = 3;
  localparam int W  = 18;

  // clock / reset
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, go;
  logic [3:0] sel, last;

  logic        busy_w  [ND];
  logic        done_w  [ND];
  logic [15:0] out_w   [ND];
  logic        state_w [ND];

  onehot_sequencer #(.SEL_W(4), .DWELL(1), .HOLD(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_i(sel),
    .last_i(last), .go_i(go), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .out_o(out_w[0]), .state_o(state_w[0]));

  onehot_sequencer #(.SEL_W(4), .DWELL(2), .HOLD(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_i(sel),
    .last_i(last), .go_i(go), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .out_o(out_w[1]), .state_o(state_w[1]));

  onehot_sequencer #(.SEL_W(4), .DWELL(3), .HOLD(1'b1)) dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_i(sel),
    .last_i(last), .go_i(go), .busy_o(busy_w[2]), .done_o(done_w[2]),
    .out_o(out_w[2]), .state_o(state_w[2]));

  // reference model
  int          line_q [ND][$];
  logic        m_busy [ND];
  logic        m_done [ND];
  logic [15:0] m_out  [ND];
  int          m_cur  [ND];
  logic [W-1:0] exp_q [ND][$];

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  function automatic int dwell_of(input int d);
    return d + 1;
  endfunction

  function automatic bit hold_of(input int d);
    return (d == 2);
  endfunction

  task automatic model_step(input int d);
    int n;
    if (rst) begin
      line_q[d].delete();
      m_busy[d] = 1'b0;
      m_done[d] = 1'b0;
      m_out[d]  = '0;
      m_cur[d]  = 0;
    end else if (!en) begin
      m_out[d]  = '0;
      m_done[d] = 1'b0;
    end else if (!m_busy[d]) begin
      m_done[d] = 1'b0;
      if (go) begin
        n = mode ? ((int'(last) - int'(sel) + 16) % 16) + 1 : 1;
        for (int k = 0; k < n; k++)
          for (int r = 0; r < dwell_of(d); r++)
            line_q[d].push_back((int'(sel) + k) % 16);
        m_cur[d]  = line_q[d].pop_front();
        m_out[d]  = 16'h1 << m_cur[d];
        m_busy[d] = 1'b1;
      end
    end else if (line_q[d].size() != 0) begin
      m_cur[d]  = line_q[d].pop_front();
      m_out[d]  = 16'h1 << m_cur[d];
      m_done[d] = 1'b0;
    end else begin
      m_busy[d] = 1'b0;
      m_done[d] = 1'b1;
      m_out[d]  = hold_of(d) ? (16'h1 << m_cur[d]) : 16'h0;
    end
    exp_q[d].push_back({m_busy[d], m_done[d], m_out[d]});
  endtask

  always @(posedge clk) begin
    cycle++;
    for (int d = 0; d < ND; d++) model_step(d);
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    for (int d = 0; d < ND; d++) begin
      if (exp_q[d].size() != 0) begin
        e = exp_q[d].pop_front();
        a = {busy_w[d], done_w[d], out_w[d]};
        tests_run++;
        if (a !== e) begin
          tests_failed++;
          $display("FAIL dut%0d cycle %0d: got busy=%b done=%b out=%h, expected busy=%b done=%b out=%h",
                   d, cycle, a[17], a[16], a[15:0], e[17], e[16], e[15:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic r, input logic e, input logic g,
                       input logic m, input logic [3:0] s, input logic [3:0] l);
    rst  = r;
    en   = e;
    go   = g;
    mode = m;
    sel  = s;
    last = l;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset for two cycles with go held high: nothing may be accepted.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd0);
    tick(2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    tick(2);

    // Full decode sweep, single mode.
    for (int s = 0; s < 16; s++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'(s), 4'd0);
      tick(1);
      go = 1'b0;
      tick(6);
    end

    // Scan with wrap 14 -> 1.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd14, 4'd1);
    tick(1);
    go = 1'b0;
    tick(14);

    // Pause scan 3..7. For the DWELL=2 instance en drops right after
    // line 5 has shown its first dwell cycle.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd7);
    tick(1);
    go = 1'b0;
    tick(4);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(25);

    // A go pulse while busy must be ignored.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd5);
    tick(1);
    go = 1'b0;
    tick(2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd9);
    tick(1);
    go = 1'b0;
    tick(20);

    // Reset in the middle of a scan.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd12);
    tick(1);
    go = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);

    // A go in the done cycle of the DWELL=1 instance.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 4'd0);
    tick(1);
    go = 1'b0;
    tick(1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd11, 4'd0);
    tick(1);
    go = 1'b0;
    tick(10);

    // The held line on the HOLD instance. Then a pause clears it, then a
    // new request replaces it.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    tick(1);
    go = 1'b0;
    tick(8);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(3);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 4'd0);
    tick(1);
    go = 1'b0;
    tick(6);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd13, 4'd0);
    tick(1);
    go = 1'b0;
    tick(6);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 149) == 0),
            1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
      tick(1);
    end

    // Drain any request that is still in flight.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    tick(60);
    #1;
    for (int d = 0; d < ND; d++) begin
      tests_run++;
      if (exp_q[d].size() != 0) begin
        tests_failed++;
        $display("FAIL drain dut%0d: got %0d pending expectations, expected 0",
                 d, exp_q[d].size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
